// File: rtl/utm_pkg.sv
// Shared definitions for the tape step controller: geometry, state encodings and helpers.
package utm_pkg;

    localparam int unsigned TAPE_LEN = 16;
    localparam int unsigned SYM_W    = 3;
    localparam int unsigned STATE_W  = 8;
    localparam int unsigned ADDR_W   = $clog2(TAPE_LEN);
    localparam int unsigned STEP_W   = 8;

    // All-zero machine state means "halt"; reset puts the machine in state bit 0.
    localparam logic [STATE_W-1:0] HALT_STATE  = '0;
    localparam logic [STATE_W-1:0] RESET_STATE = STATE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_MOVE   = 3'd3,
        ST_HALTED = 3'd4
    } fsm_state_t;

    // True when more than one bit of v is set.
    function automatic logic is_multi_hot(input logic [STATE_W-1:0] v);
        return (v & (v - STATE_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/tape_mem.sv
// Tape register file: one synchronous write port, two combinational read ports,
// synchronous clear on reset.
//   clk, reset        : clock, synchronous active-high clear of every cell
//   we, waddr, wdata  : write port
//   raddr_a / rdata_a : read port A (head)
//   raddr_b / rdata_b : read port B (observation)
module tape_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Cell storage; reset clears the whole tape so no in-flight write survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/tape_step_ctrl.sv
// Turing-machine tape step controller. Each step runs READ -> WRITE -> MOVE:
// read the symbol under the head, write the externally computed symbol back,
// move the head and adopt the externally computed one-hot state.
//   clk, reset          : clock, synchronous active-high reset
//   load_valid/addr/sym : tape preload, honoured only in IDLE
//   go, run             : single-step pulse / continuous stepping level
//   new_sym, next_state, move_right : external new-symbol / next-state / direction logic
//   state_out, sym_out, head, steps : machine state, symbol under head, head, step count
//   busy, halted        : combinational FSM status
//   err, wrapped        : sticky flags (invalid next_state, head wrap-around)
//   rd_addr, rd_sym     : combinational tape observation port
module tape_step_ctrl #(
    parameter int unsigned TAPE_LEN = utm_pkg::TAPE_LEN,
    parameter int unsigned SYM_W    = utm_pkg::SYM_W,
    parameter int unsigned STATE_W  = utm_pkg::STATE_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    input  logic [$clog2(TAPE_LEN)-1:0] load_addr,
    input  logic [SYM_W-1:0]            load_sym,
    input  logic                        go,
    input  logic                        run,
    input  logic [SYM_W-1:0]            new_sym,
    input  logic [STATE_W-1:0]          next_state,
    input  logic                        move_right,
    output logic [STATE_W-1:0]          state_out,
    output logic [SYM_W-1:0]            sym_out,
    output logic [$clog2(TAPE_LEN)-1:0] head,
    output logic                        busy,
    output logic                        halted,
    output logic                        err,
    output logic                        wrapped,
    output logic [7:0]                  steps,
    input  logic [$clog2(TAPE_LEN)-1:0] rd_addr,
    output logic [SYM_W-1:0]            rd_sym
);

    localparam int unsigned ADDR_W = $clog2(TAPE_LEN);
    localparam int unsigned STEP_W = 8;
    localparam logic [ADDR_W-1:0]  HEAD_MAX    = ADDR_W'(TAPE_LEN - 1);
    localparam logic [STATE_W-1:0] HALT_ST     = '0;
    localparam logic [STATE_W-1:0] RESET_ST    = STATE_W'(1);

    utm_pkg::fsm_state_t state_q, state_d;

    logic                tape_we;
    logic [ADDR_W-1:0]   tape_waddr;
    logic [SYM_W-1:0]    tape_wdata;
    logic [SYM_W-1:0]    head_sym;
    logic                sym_ld;
    logic                sample;
    logic                step_done;
    logic                err_set;

    logic [STATE_W-1:0]  ns_q;
    logic                dir_q;
    logic [STATE_W-1:0]  state_out_q;
    logic [SYM_W-1:0]    sym_q;
    logic [ADDR_W-1:0]   head_q;
    logic [STEP_W-1:0]   steps_q;
    logic                err_q;
    logic                wrapped_q;

    tape_mem #(
        .DEPTH (TAPE_LEN),
        .WIDTH (SYM_W)
    ) u_tape (
        .clk     (clk),
        .reset   (reset),
        .we      (tape_we),
        .waddr   (tape_waddr),
        .wdata   (tape_wdata),
        .raddr_a (head_q),
        .rdata_a (head_sym),
        .raddr_b (rd_addr),
        .rdata_b (rd_sym)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= utm_pkg::ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d    = state_q;
        tape_we    = 1'b0;
        tape_waddr = head_q;
        tape_wdata = new_sym;
        sym_ld     = 1'b0;
        sample     = 1'b0;
        step_done  = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            utm_pkg::ST_IDLE: begin
                // A preload coinciding with go/run is still performed.
                if (load_valid) begin
                    tape_we    = 1'b1;
                    tape_waddr = load_addr;
                    tape_wdata = load_sym;
                end
                if (go || run) begin
                    state_d = utm_pkg::ST_READ;
                end
            end
            utm_pkg::ST_READ: begin
                sym_ld  = 1'b1;
                state_d = utm_pkg::ST_WRITE;
            end
            utm_pkg::ST_WRITE: begin
                if (next_state == HALT_ST) begin
                    state_d = utm_pkg::ST_HALTED;
                end else if (utm_pkg::is_multi_hot(next_state)) begin
                    err_set = 1'b1;
                    state_d = utm_pkg::ST_HALTED;
                end else begin
                    tape_we = 1'b1;
                    sample  = 1'b1;
                    state_d = utm_pkg::ST_MOVE;
                end
            end
            utm_pkg::ST_MOVE: begin
                step_done = 1'b1;
                state_d   = run ? utm_pkg::ST_READ : utm_pkg::ST_IDLE;
            end
            utm_pkg::ST_HALTED: begin
                state_d = utm_pkg::ST_HALTED;
            end
            default: begin
                state_d = utm_pkg::ST_IDLE;
            end
        endcase
    end

    // Step datapath: symbol latch, WRITE-time sampling, MOVE-time head/state/counter update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ns_q        <= RESET_ST;
            dir_q       <= 1'b0;
            state_out_q <= RESET_ST;
            sym_q       <= '0;
            head_q      <= '0;
            steps_q     <= '0;
            err_q       <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            if (sym_ld) begin
                sym_q <= head_sym;
            end
            if (sample) begin
                ns_q  <= next_state;
                dir_q <= move_right;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (step_done) begin
                state_out_q <= ns_q;
                if (steps_q != '1) begin
                    steps_q <= steps_q + STEP_W'(1);
                end
                if (dir_q) begin
                    if (head_q == HEAD_MAX) begin
                        head_q    <= '0;
                        wrapped_q <= 1'b1;
                    end else begin
                        head_q <= head_q + ADDR_W'(1);
                    end
                end else begin
                    if (head_q == '0) begin
                        head_q    <= HEAD_MAX;
                        wrapped_q <= 1'b1;
                    end else begin
                        head_q <= head_q - ADDR_W'(1);
                    end
                end
            end
        end
    end

    // Status decoded directly from the FSM state.
    always_comb begin
        busy   = (state_q == utm_pkg::ST_READ) || (state_q == utm_pkg::ST_WRITE) ||
                 (state_q == utm_pkg::ST_MOVE);
        halted = (state_q == utm_pkg::ST_HALTED);
    end

    assign state_out = state_out_q;
    assign sym_out   = sym_q;
    assign head      = head_q;
    assign steps     = steps_q;
    assign err       = err_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_tape_step_ctrl.sv
// Self-checking bench for tape_step_ctrl against a step-level behavioural model.
module tb_tape_step_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [3:0] load_addr;
    logic [2:0] load_sym;
    logic       go;
    logic       run;
    logic [2:0] new_sym;
    logic [7:0] next_state;
    logic       move_right;
    logic [7:0] state_out;
    logic [2:0] sym_out;
    logic [3:0] head;
    logic       busy;
    logic       halted;
    logic       err;
    logic       wrapped;
    logic [7:0] steps;
    logic [3:0] rd_addr;
    logic [2:0] rd_sym;

    int checks = 0;
    int errors = 0;

    // Reference model: whole-step semantics with plain integers.
    int         m_tape [16];
    int         m_head;
    int         m_state;
    int         m_steps;
    int         m_sym;
    bit         m_err;
    bit         m_wrapped;
    bit         m_halted;

    tape_step_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_sym   (load_sym),
        .go         (go),
        .run        (run),
        .new_sym    (new_sym),
        .next_state (next_state),
        .move_right (move_right),
        .state_out  (state_out),
        .sym_out    (sym_out),
        .head       (head),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .wrapped    (wrapped),
        .steps      (steps),
        .rd_addr    (rd_addr),
        .rd_sym     (rd_sym)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tape[i] = 0;
        m_head = 0; m_state = 1; m_steps = 0; m_sym = 0;
        m_err = 1'b0; m_wrapped = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input int ns, input int sym, input bit dir);
        if (m_halted) return;
        m_sym = m_tape[m_head];
        if (ns == 0) begin
            m_halted = 1'b1;
        end else if ($countones(ns) > 1) begin
            m_err = 1'b1;
            m_halted = 1'b1;
        end else begin
            m_tape[m_head] = sym;
            if (dir) begin
                if (m_head == 15) m_wrapped = 1'b1;
                m_head = (m_head + 1) % 16;
            end else begin
                if (m_head == 0) m_wrapped = 1'b1;
                m_head = (m_head + 15) % 16;
            end
            m_steps = (m_steps < 255) ? m_steps + 1 : 255;
            m_state = ns;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state_out"}, 32'(state_out), 32'(m_state));
        check({tag, ".head"},      32'(head),      32'(m_head));
        check({tag, ".steps"},     32'(steps),     32'(m_steps));
        check({tag, ".err"},       32'(err),       32'(m_err));
        check({tag, ".wrapped"},   32'(wrapped),   32'(m_wrapped));
        check({tag, ".halted"},    32'(halted),    32'(m_halted));
        check({tag, ".busy"},      32'(busy),      32'(0));
        check({tag, ".sym_out"},   32'(sym_out),   32'(m_sym));
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("%s.tape[%0d]", tag, i), 32'(rd_sym), 32'(m_tape[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; run = 1'b0; load_valid = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic preload(input int addr, input int sym);
        load_valid = 1'b1; load_addr = 4'(addr); load_sym = 3'(sym);
        tick();
        load_valid = 1'b0;
        m_tape[addr] = sym;
    endtask

    // One go-initiated step with optional preload in IDLE (performed) or READ (ignored).
    task automatic step_go(input string tag, input int ns, input int sym, input bit dir,
                           input bit ld_idle, input bit ld_read, input int laddr, input int lsym);
        int old_head;
        new_sym = 3'(sym); next_state = 8'(ns); move_right = dir;
        go = 1'b1;
        if (ld_idle) begin
            load_valid = 1'b1; load_addr = 4'(laddr); load_sym = 3'(lsym);
            m_tape[laddr] = lsym;
        end
        tick();
        go = 1'b0; load_valid = 1'b0;
        check({tag, ".busy_read"}, 32'(busy), 32'(1));
        if (ld_read) begin
            load_valid = 1'b1; load_addr = 4'(laddr); load_sym = 3'(lsym);
        end
        tick();
        load_valid = 1'b0;
        check({tag, ".sym_read"}, 32'(sym_out), 32'(m_tape[m_head]));
        old_head = m_head;
        model_step(ns, sym, dir);
        tick();
        if (m_halted) begin
            check({tag, ".halted_now"}, 32'(halted), 32'(1));
        end else begin
            rd_addr = 4'(old_head);
            #1;
            check({tag, ".rd_after_write"}, 32'(rd_sym), 32'(sym));
            tick();
        end
        check_all(tag);
    endtask

    // Continuous stepping with one-hot next states; dir_mode -1 random, else fixed.
    task automatic run_steps(input string tag, input int n, input int dir_mode);
        int ns, sym;
        bit dir;
        run = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            ns  = 1 << $urandom_range(0, 7);
            sym = int'($urandom_range(0, 7));
            dir = (dir_mode < 0) ? 1'($urandom) : 1'(dir_mode);
            new_sym = 3'(sym); next_state = 8'(ns); move_right = dir;
            tick();
            check({tag, ".sym_read"}, 32'(sym_out), 32'(m_tape[m_head]));
            model_step(ns, sym, dir);
            tick();
            if (i == n - 1) run = 1'b0;
            tick();
            check({tag, ".steps"}, 32'(steps), 32'(m_steps));
            check({tag, ".head"},  32'(head),  32'(m_head));
        end
        check_all(tag);
    endtask

    task automatic halted_go(input string tag);
        go = 1'b1; run = 1'b1;
        repeat (4) tick();
        go = 1'b0; run = 1'b0;
        tick();
        check_all(tag);
    endtask

    initial begin
        int kind, ns, a, b;
        reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_sym = '0;
        go = 1'b0; run = 1'b0; new_sym = '0; next_state = '0; move_right = 1'b0;
        rd_addr = '0;
        tick();
        do_reset();
        check_all("reset");

        // Basic single step from a preloaded cell.
        preload(0, 1);
        step_go("basic", 8'h02, 3'b100, 1'b1, 1'b0, 1'b0, 0, 0);

        // Move left from 0 wraps to 15.
        do_reset();
        step_go("wrap_left", 8'h04, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0);

        // Sixteen right moves from 0 wraps 15 -> 0.
        do_reset();
        run_steps("wrap_right", 16, 1);

        // Zero next_state halts without touching tape/head/steps; go then ignored.
        do_reset();
        preload(3, 5);
        step_go("pre_halt", 8'h10, 3'b110, 1'b1, 1'b0, 1'b0, 0, 0);
        step_go("halt", 8'h00, 3'b111, 1'b1, 1'b0, 1'b0, 0, 0);
        halted_go("halt_ignore");

        // Multi-hot next_state flags err and halts without writing.
        do_reset();
        preload(0, 2);
        step_go("err", 8'h05, 3'b111, 1'b1, 1'b0, 1'b0, 0, 0);
        halted_go("err_ignore");

        // Load during READ is ignored; load coinciding with go is performed.
        do_reset();
        step_go("ld_read", 8'h08, 3'b001, 1'b1, 1'b0, 1'b1, 5, 7);
        step_go("ld_idle", 8'h20, 3'b010, 1'b1, 1'b1, 1'b0, 1, 6);

        // Saturating step counter.
        do_reset();
        run_steps("sat", 300, -1);

        // Reset in WRITE wipes everything including the tape.
        preload(9, 4);
        next_state = 8'h02; new_sym = 3'b101; move_right = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        check("rst_mid.busy", 32'(busy), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_all("rst_mid");

        // Randomized single steps with preloads and occasional halts.
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) preload(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                ns = 0;
            end else if (kind == 1) begin
                a  = int'($urandom_range(0, 7));
                b  = (a + int'($urandom_range(1, 7))) % 8;
                ns = (1 << a) | (1 << b);
            end else begin
                ns = 1 << $urandom_range(0, 7);
            end
            step_go($sformatf("rand%0d", it), ns, int'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            if (m_halted) begin
                halted_go($sformatf("rand%0d_h", it));
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tape_step_ctrl.md
TAPE_STEP_CTRL -- requirements
Module: tape_step_ctrl

Interface
REQ-001 SHALL have parameters: TAPE_LEN, 16, tape cells; SYM_W, 3, symbol width; STATE_W, 8, one-hot state width.
REQ-002 SHALL have ports, one per line, clock and reset first:
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  synchronous, active-high reset
  load_valid  in  1  tape preload strobe; honoured only in IDLE
  load_addr  in  4  preload cell index
  load_sym  in  3  preload symbol
  go  in  1  single-step request pulse
  run  in  1  level; continuous stepping while high
  new_sym  in  3  symbol to write (z2..z0 from new-symbol logic)
  next_state  in  8  next one-hot state from next-state logic
  move_right  in  1  head direction: 1 = +1, 0 = -1
  state_out  out  8  current one-hot machine state
  sym_out  out  3  registered symbol under head (s2..s0)
  head  out  4  head position
  busy  out  1  high in READ, WRITE, MOVE
  halted  out  1  high in HALTED
  err  out  1  sticky; next_state not one-hot and not zero
  wrapped  out  1  sticky; head crossed 15<->0
  steps  out  8  completed-step counter, saturating at 255
  rd_addr  in  4  observation read address
  rd_sym  out  3  combinational tape[rd_addr]

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, MOVE, HALTED.
REQ-004 SHALL in IDLE write load_sym to tape[load_addr] when load_valid is high; load_valid ignored in all other states.
REQ-005 SHALL leave IDLE for READ when go or run is high; if load_valid coincides, perform the load and still go to READ.
REQ-006 SHALL in READ register tape[head] into sym_out; sym_out is stable through WRITE.
REQ-007 SHALL in WRITE sample new_sym, next_state, move_right; if next_state == 0 go to HALTED without writing tape or moving head.
REQ-008 SHALL in WRITE, if next_state has more than one bit set, set err and go to HALTED without writing.
REQ-009 SHALL otherwise in WRITE write new_sym to tape[head] and go to MOVE.
REQ-010 SHALL in MOVE update head by +/-1 modulo 16, load state_out from sampled next_state, increment steps (saturating).
REQ-011 SHALL set wrapped when MOVE takes head 15->0 or 0->15.
REQ-012 SHALL leave MOVE for READ if run is high, else IDLE; a step is exactly 3 cycles (READ, WRITE, MOVE).
REQ-013 SHALL ignore go/run in HALTED; exit only via reset.
REQ-014 SHALL drive busy and halted combinationally from FSM state.
REQ-015 SHALL make rd_sym reflect a tape write on the cycle after the write edge.

Reset
REQ-016 SHALL on reset set FSM=IDLE, state_out=8'h01, head=0, sym_out=0, steps=0, err=0, wrapped=0, all tape cells=0.
REQ-017 SHALL let reset override every other input, including mid-step; no partial write survives reset.

Structure
REQ-018 SHALL place FSM state enum, TAPE_LEN, SYM_W, STATE_W and HALT_STATE (all zeros) in shared package utm_pkg.
REQ-019 SHALL use one sub-module tape_mem: 16x3 register file, one sync write port, two combinational read ports (head, rd_addr), sync reset clear.

Verification
REQ-020 Preload tape[0]=3'b001, go pulse, next_state=8'h02, new_sym=3'b100, move_right=1 -> after 3 cycles tape[0]=3'b100, head=1, state_out=8'h02, steps=1, FSM IDLE.
REQ-021 head=15, move_right=1, run high -> head=0, wrapped=1; head=0, move_right=0 -> head=15.
REQ-022 next_state=8'h00 in WRITE -> halted=1, tape and head unchanged, steps unchanged; later go -> no change.
REQ-023 next_state=8'h05 in WRITE -> err=1, halted=1, no tape write.
REQ-024 run held for 300 steps -> steps saturates at 255; reset asserted during WRITE -> next cycle all REQ-016 values.
REQ-025 load_valid in READ with load_addr=5 -> tape[5] unchanged via rd_sym.
